// File: rtl/mc_fir_pkg.sv
// ---------------------------------------------------------------------------
// mc_fir_pkg : shared types and elaboration helpers for mc_fir_filter
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mc_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } fir_state_e;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Passthrough tap; 2^frac is clamped to the largest positive coefficient
  // when it does not fit, so the default filter is unity gain to within 1 LSB.
  function automatic logic signed [63:0] default_coef(input int idx, input int frac,
                                                      input int coef_w);
    logic signed [63:0] max_pos;
    logic signed [63:0] unity;
    max_pos = (64'sd1 << (coef_w - 1)) - 64'sd1;
    unity   = 64'sd1 << frac;
    if (idx != 0) return '0;
    if (unity > max_pos) return max_pos;
    return unity;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_fir_history.sv
// ---------------------------------------------------------------------------
// mc_fir_history : per-channel circular delay lines with tap address generation
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mc_fir_history #(
  parameter int DATA_W   = 12,
  parameter int TAPS     = 40,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1,
  parameter int TAP_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [CH_W-1:0]          wr_ch_i,
  input  logic signed [DATA_W-1:0] wr_data_i,
  input  logic [CH_W-1:0]          rd_ch_i,
  input  logic [TAP_W-1:0]         rd_tap_i,
  output logic signed [DATA_W-1:0] rd_data_o
);

  logic signed [DATA_W-1:0] mem_q [CHANNELS][TAPS];
  logic [TAP_W-1:0]         ptr_q [CHANNELS];
  logic [TAP_W-1:0]         w_rd_ptr;
  logic [TAP_W:0]           w_rd_sum;
  logic [TAP_W-1:0]         w_rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) mem_q[c][t] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en_i && (wr_ch_i == CH_W'(c))) begin
          for (int t = 0; t < TAPS; t++) begin
            if (ptr_q[c] == TAP_W'(t)) mem_q[c][t] <= wr_data_i;
          end
          ptr_q[c] <= (ptr_q[c] == TAP_W'(TAPS - 1)) ? '0 : ptr_q[c] + TAP_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_rd_ptr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_ch_i == CH_W'(c)) w_rd_ptr = ptr_q[c];
    end
  end

  // The pointer sits one past the newest sample, so tap k lives at ptr-1-k mod TAPS.
  assign w_rd_sum  = {1'b0, w_rd_ptr} + (TAP_W+1)'(TAPS - 1) - {1'b0, rd_tap_i};
  assign w_rd_addr = (w_rd_sum >= (TAP_W+1)'(TAPS)) ?
                     TAP_W'(w_rd_sum - (TAP_W+1)'(TAPS)) : w_rd_sum[TAP_W-1:0];

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int t = 0; t < TAPS; t++) begin
        if ((rd_ch_i == CH_W'(c)) && (w_rd_addr == TAP_W'(t))) rd_data_o = mem_q[c][t];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc_fir_filter.sv
// ---------------------------------------------------------------------------
// mc_fir_filter : multi-channel FIR, one shared MAC, TAPS+2 cycles per sample
//                 Define FIR_SAT_EN to clamp the output instead of wrapping.
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mc_fir_filter
  import mc_fir_pkg::*;
#(
  parameter  int DATA_W   = 12,
  parameter  int COEF_W   = 16,
  parameter  int TAPS     = 40,
  parameter  int CHANNELS = 2,
  parameter  int FRAC     = 15,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (FRAC - 1);

  fir_state_e               state_q, state_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic signed [COEF_W-1:0] coef_q [TAPS];

  logic                     w_idle;
  logic                     w_start;
  logic signed [DATA_W-1:0] w_hist;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W:0]    w_rnd_sum;
  logic signed [DATA_W-1:0] w_res;

  assign w_idle   = (state_q == ST_IDLE);
  assign in_ready = w_idle;
  // Out-of-range channels are accepted and dropped without leaving IDLE.
  assign w_start  = in_valid && w_idle && (32'(in_ch) < CHANNELS);

  mc_fir_history #(
    .DATA_W   (DATA_W),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W),
    .TAP_W    (TAP_W)
  ) u_history (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_start),
    .wr_ch_i   (in_ch),
    .wr_data_i (in_data),
    .rd_ch_i   (ch_q),
    .rd_tap_i  (tap_q),
    .rd_data_o (w_hist)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF_W'(default_coef(i, FRAC, COEF_W));
    end else if (coef_we && w_idle) begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_addr == TAP_W'(i)) coef_q[i] <= coef_data;
      end
    end
  end

  assign w_coef    = coef_q[tap_q];
  assign w_prod    = w_hist * w_coef;
  assign w_rnd_sum = {acc_q[ACC_W-1], acc_q} + RND;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 << (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(64'sd1 << (DATA_W - 1)));
  logic signed [ACC_W:0] w_rnd;
  assign w_rnd = w_rnd_sum >>> FRAC;
  always_comb begin
    if (w_rnd > SAT_MAX)      w_res = SAT_MAX[DATA_W-1:0];
    else if (w_rnd < SAT_MIN) w_res = SAT_MIN[DATA_W-1:0];
    else                      w_res = w_rnd[DATA_W-1:0];
  end
`else
  assign w_res = DATA_W'(w_rnd_sum >>> FRAC);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          state_d = ST_MAC;
          tap_d   = '0;
          ch_d    = in_ch;
          acc_d   = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        if (tap_q == TAP_W'(TAPS - 1)) state_d = ST_ROUND;
        else                           tap_d   = tap_q + TAP_W'(1);
      end
      ST_ROUND: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        out_data_d  = w_res;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_fir_filter.sv
// ---------------------------------------------------------------------------
// tb_mc_fir_filter : directed vector bench for mc_fir_filter (TAPS=4, 2 channels)
// Revision         : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_fir_filter;

  localparam int DATA_W   = 12;
  localparam int COEF_W   = 16;
  localparam int TAPS     = 4;
  localparam int CHANNELS = 2;
  localparam int FRAC     = 15;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [0:0]               in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [1:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic [0:0]               out_ch;
  logic signed [DATA_W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit do_load;
    int coef;
    int ch;
    int data;
    int exp;
  } vec_t;

  vec_t vecs[14];

  mc_fir_filter #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS),
    .FRAC     (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = addr[1:0];
    coef_data = val[COEF_W-1:0];
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic load_all(input int val);
    for (int i = 0; i < TAPS; i++) write_coef(i, val);
  endtask

  // mode 0: plain, 1: c[0] write in accept cycle, 2: c[0] write in MAC cycle 2,
  // 3: reset pulse in MAC cycle 3 (no result expected)
  task automatic send(input int ch, input int data, input int exp, input int mode, input int wd);
    int lat;
    bit got;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_ch    = ch[0:0];
    in_data  = data[DATA_W-1:0];
    if (mode == 1) begin
      coef_we   = 1'b1;
      coef_addr = 2'd0;
      coef_data = wd[COEF_W-1:0];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    coef_we  = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (mode == 2) begin
        coef_we   = (k == 2);
        coef_addr = 2'd0;
        coef_data = wd[COEF_W-1:0];
      end
      if (mode == 3) rst = (k == 3);
      if (out_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
      @(negedge clk);
    end
    coef_we = 1'b0;
    if (mode == 3) begin
      chk("abort_no_out_valid", int'(got), 0);
      chk("abort_ready", int'(in_ready), 1);
    end else begin
      chk("latency", got ? lat : -1, TAPS + 2);
      chk("ready_with_out_valid", int'(in_ready), 1);
      chk("out_data", int'($signed(out_data)), exp);
      chk("out_ch", int'(out_ch), ch);
      @(negedge clk);
      chk("out_valid_single", int'(out_valid), 0);
      chk("out_data_hold", int'($signed(out_data)), exp);
    end
  endtask

  initial begin
    int e2, e3, e4, accepts;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;

`ifdef FIR_SAT_EN
    e2 = 2047; e3 = 2047; e4 = 2047;
`else
    e2 = -2;   e3 = 2045; e4 = -4;
`endif
    vecs[0]  = '{1'b1, 16384, 0, 1000, 500};
    vecs[1]  = '{1'b0, 0,     1, -800, -400};
    vecs[2]  = '{1'b0, 0,     0, 0,    500};
    vecs[3]  = '{1'b0, 0,     1, 0,    -400};
    vecs[4]  = '{1'b0, 0,     0, 0,    500};
    vecs[5]  = '{1'b0, 0,     1, 0,    -400};
    vecs[6]  = '{1'b0, 0,     0, 0,    500};
    vecs[7]  = '{1'b0, 0,     1, 0,    -400};
    vecs[8]  = '{1'b0, 0,     0, 0,    0};
    vecs[9]  = '{1'b0, 0,     1, 0,    0};
    vecs[10] = '{1'b1, 32767, 0, 2047, 2047};
    vecs[11] = '{1'b0, 0,     0, 2047, e2};
    vecs[12] = '{1'b0, 0,     0, 2047, e3};
    vecs[13] = '{1'b0, 0,     0, 2047, e4};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_data", int'($signed(out_data)), 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_load) load_all(vecs[i].coef);
      send(vecs[i].ch, vecs[i].data, vecs[i].exp, 0, 0);
    end

    accepts = 0;
    in_valid = 1'b1; in_ch = 1'b1; in_data = '0;
    for (int c = 0; c < 20; c++) begin
      chk("bp_in_ready", int'(in_ready), ((c % (TAPS + 2)) == 0) ? 1 : 0);
      if (in_ready) accepts++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_accepts", accepts, 4);
    repeat (10) @(negedge clk);

    send(0, 1000, 0, 3, 0);
    send(0, 1000, 1000, 0, 0);

    send(1, 100, 100, 2, 16384);
    send(0, 200, 200, 0, 0);
    write_coef(0, 16384);
    send(0, 300, 150, 0, 0);
    send(0, 400, 100, 1, 8192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mc_fir_filter.md
MC_FIR_FILTER -- requirements
Module: mc_fir_filter

Interface
REQ-001 SHALL have parameter DATA_W, 12, signed sample width in and out.
REQ-002 SHALL have parameter COEF_W, 16, signed coefficient width.
REQ-003 SHALL have parameter TAPS, 40, filter order plus one; legal range 2..64.
REQ-004 SHALL have parameter CHANNELS, 2, number of independent channels sharing one MAC; legal range 1..8.
REQ-005 SHALL have parameter FRAC, 15, number of fractional coefficient bits removed at output.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, sample offered.
REQ-009 SHALL have port in_ready, output, 1, sample accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port in_ch, input, CH_W=max(1,clog2(CHANNELS)), channel of the offered sample.
REQ-011 SHALL have port in_data, input, DATA_W, signed sample.
REQ-012 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-013 SHALL have port coef_addr, input, clog2(TAPS), tap index.
REQ-014 SHALL have port coef_data, input, COEF_W, signed coefficient.
REQ-015 SHALL have port out_valid, output, 1, single-cycle result strobe.
REQ-016 SHALL have port out_ch, output, CH_W, channel of the result.
REQ-017 SHALL have port out_data, output, DATA_W, signed filtered sample.

Function
REQ-018 SHALL implement y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k], with separate history per channel and shared coefficients.
REQ-019 SHALL use an FSM with states IDLE, MAC and ROUND.
REQ-020 SHALL transition IDLE->MAC on accept, MAC->ROUND after exactly TAPS MAC cycles, and ROUND->IDLE.
REQ-021 SHALL drive in_ready high only in IDLE.
REQ-022 SHALL, on accept at cycle 0, write the sample into that channel's circular delay line and clear the accumulator.
REQ-023 SHALL perform one multiply-accumulate per cycle in cycles 1..TAPS.
REQ-024 SHALL compute the result in ROUND (cycle TAPS+1).
REQ-025 SHALL pulse out_valid for one cycle at cycle TAPS+2, with in_ready high in that same cycle, giving throughput of one sample per TAPS+2 cycles.
REQ-026 SHALL size the accumulator at DATA_W+COEF_W+clog2(TAPS) bits so that it never overflows.
REQ-027 SHALL produce out_data = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift, round half up.
REQ-028 SHALL, when in_ch >= CHANNELS, accept the sample, discard it, leave all histories unchanged and generate no out_valid.
REQ-029 SHALL advance a per-channel write pointer that wraps from TAPS-1 to 0.
REQ-030 SHALL honour coefficient writes only in IDLE, and a write there SHALL take effect for the next accepted sample.
REQ-031 SHALL silently drop coefficient writes in MAC or ROUND.
REQ-032 SHALL, when coef_we and an accept occur in the same IDLE cycle, use the new coefficient for that sample.
REQ-033 SHALL hold out_ch and out_data stable until the next out_valid.

Reset
REQ-034 SHALL, on rst, force the FSM to IDLE, in_ready=1, out_valid=0, out_ch=0 and out_data=0.
REQ-035 SHALL, on rst, zero all delay lines and pointers.
REQ-036 SHALL, on rst, load coefficients with the package default (c[0]=2^FRAC, all others 0, i.e. passthrough).
REQ-037 SHALL, when rst asserts mid-MAC, abort the computation and produce no out_valid for it.

Configuration
REQ-038 SHALL, with FIR_SAT_EN defined, clamp the rounded result to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-039 SHALL, without FIR_SAT_EN, truncate the rounded result to its low DATA_W bits (two's-complement wrap).

Structure
REQ-040 SHALL place the state enum, accumulator-width function and default-coefficient function in package mc_fir_pkg.
REQ-041 SHALL implement the delay-line storage (CHANNELS x TAPS words, per-channel pointers and read address generation) as sub-module mc_fir_history.

Verification
REQ-042 SHALL pass impulse response: TAPS=4, FRAC=15, coefficients all 16384, channel 0 input 1000 then zeros -> out_data 500,500,500,500,0, out_valid at cycle TAPS+2=6 after each accept.
REQ-043 SHALL pass channel isolation: CHANNELS=2, channel 0 fed 1000 and channel 1 fed -800 interleaved with the REQ-042 coefficients -> channel 0 yields 500s and channel 1 yields -400s, with no cross-talk.
REQ-044 SHALL pass saturation: all coefficients 32767 and input 2047 repeated -> out_data 2047 with FIR_SAT_EN, and the wrapped low 12 bits without it.
REQ-045 SHALL pass backpressure: in_valid held high for 20 cycles -> exactly one accept per TAPS+2 cycles and in_ready low throughout MAC and ROUND.
REQ-046 SHALL pass reset mid-operation: rst pulsed at cycle 3 of MAC -> no out_valid, and the next input 1000 with the default coefficients -> out_data 1000.
REQ-047 SHALL pass dropped coefficient write: coef_we during MAC -> coefficient unchanged on the next sample; the same write in IDLE -> applied.
